// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sequencer state codes and timing defaults.
package uart_tx_fifo_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int BUSY_TIMEOUT_DEFAULT = 3;

  // Width of a down-counter that must hold max_val; never narrower than one bit.
  function automatic int timer_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port, FIFO status and transmitter handshake of uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);

  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              txd_start;
  logic [7:0]        txd_data;
  logic              txd_busy;

  modport master (
    output wr_en, wr_data, txd_busy,
    input  full, empty, count, overflow, txd_start, txd_data
  );

  modport slave (
    input  wr_en, wr_data, txd_busy,
    output full, empty, count, overflow, txd_start, txd_data
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic synchronous FIFO with registered read port, registered flags and sticky overflow.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              overflow_reg;
  logic [WIDTH-1:0]  rd_data_reg;
  logic              push;
  logic              pop;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken then.
  assign pop  = rd_en && !empty_reg;
  assign push = wr_en && (!full_reg || pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      count_reg <= count_next;
      full_reg  <= (count_next == (ADDR_W + 1)'(DEPTH));
      empty_reg <= (count_next == '0);
      if (wr_en && full_reg && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding async_transmitter: absorbs bursts and issues one start pulse per byte.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int TIMER_W = timer_width(BUSY_TIMEOUT);

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_next;
  logic               start_reg;
  logic               start_next;
  logic               fifo_empty;
  logic               pop;

  assign pop = (state_reg == IDLE) && !fifo_empty && !bus.txd_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (bus.txd_data),
    .full     (bus.full),
    .empty    (fifo_empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          start_next = 1'b1;
          timer_next = TIMER_W'(BUSY_TIMEOUT);
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // The start-pulse cycle is not part of the timeout: busy cannot have risen yet.
        if (bus.txd_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == '0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.txd_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      start_reg <= start_next;
    end
  end

  assign bus.empty     = fifo_empty;
  assign bus.txd_start = start_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a queue-based reference model checked every cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(4)) bus();

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .ADDR_W       (4),
    .BUSY_TIMEOUT (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] last_m = 8'h00;
  logic       prev_start = 1'b0;
  logic [7:0] sent_data[$];
  int         sent_cyc[$];

  bit   busy_auto = 1'b0;
  logic busy_force = 1'b0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int b = budget;
    while (sent_data.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    if (sent_data.size() < n) begin
      errors++;
      $display("FAIL %s: saw %0d starts, expected %0d within %0d cycles", name, sent_data.size(), n, budget);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.wr_en = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
  endtask

  // Transmitter stand-in: busy for 20 cycles starting the cycle after each start pulse.
  always @(negedge clk) begin
    #1;
    if (busy_cnt > 0) begin
      bus.txd_busy = 1'b1;
      busy_cnt--;
    end else begin
      bus.txd_busy = busy_force;
    end
    if (busy_auto && bus.txd_start === 1'b1) busy_cnt = 20;
  end

  // Reference model: FIFO contents as a queue, updated once per clock edge.
  always begin
    logic rn_s, we_s, busy_s, pop;
    logic [7:0] wd_s, exp_b;
    int occ0;
    @(posedge clk);
    rn_s   = reset_n;
    we_s   = bus.wr_en;
    wd_s   = bus.wr_data;
    busy_s = bus.txd_busy;
    #1;
    cyc++;
    if (!rn_s) begin
      exp_q.delete();
      ovf_m  = 1'b0;
      last_m = 8'h00;
      check("rst_start", bus.txd_start, 0);
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_txd_data", bus.txd_data, 8'h00);
    end else begin
      occ0 = exp_q.size();
      pop  = (bus.txd_start === 1'b1);
      if (pop) begin
        check("start_while_busy", busy_s, 0);
        check("start_back_to_back", prev_start, 0);
        checks++;
        if (occ0 == 0) begin
          errors++;
          $display("FAIL start_on_empty: got start with model count 0 (cycle %0d)", cyc);
        end else begin
          exp_b = exp_q.pop_front();
          check("txd_data_at_start", bus.txd_data, exp_b);
          last_m = exp_b;
        end
        sent_data.push_back(bus.txd_data);
        sent_cyc.push_back(cyc);
      end
      if (we_s && occ0 == DEPTH && !pop) ovf_m = 1'b1;
      if (we_s && (occ0 < DEPTH || pop)) exp_q.push_back(wd_s);
      check("count", bus.count, exp_q.size());
      check("empty", bus.empty, exp_q.size() == 0);
      check("full", bus.full, exp_q.size() == DEPTH);
      check("overflow", bus.overflow, ovf_m);
      check("txd_data_hold", bus.txd_data, last_m);
    end
    prev_start = bus.txd_start;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n0, n1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("init_count", bus.count, 0);
    check("init_empty", bus.empty, 1);

    // Single byte: start two cycles after the write.
    n0 = sent_data.size();
    write_byte(8'hA5);
    w = cyc;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("single_empty_next", bus.empty, 0);
    wait_starts("single_wait", n0 + 1, 20);
    check("single_latency", sent_cyc[n0] - w, 2);
    check("single_data", sent_data[n0], 8'hA5);
    repeat (8) @(negedge clk);
    check("single_count_after", bus.count, 0);
    check("single_empty_after", bus.empty, 1);

    // Burst of 16 against a 20-cycle busy transmitter.
    busy_auto = 1'b1;
    n0 = sent_data.size();
    for (int i = 0; i < 16; i++) write_byte(8'(i + 1));
    idle_cycles(0);
    wait_starts("burst_wait", n0 + 16, 1000);
    for (int i = 0; i < 16; i++) begin
      check("burst_data", sent_data[n0 + i], 8'(i + 1));
      if (i > 0) begin
        checks++;
        if (sent_cyc[n0 + i] - sent_cyc[n0 + i - 1] < 21) begin
          errors++;
          $display("FAIL burst_gap: gap %0d cycles, required at least 21", sent_cyc[n0 + i] - sent_cyc[n0 + i - 1]);
        end
      end
    end
    check("burst_overflow", bus.overflow, 0);
    repeat (30) @(negedge clk);
    busy_auto = 1'b0;

    // Overflow: 17 writes while the transmitter is held busy.
    busy_force = 1'b1;
    n0 = sent_data.size();
    for (int i = 0; i < 17; i++) write_byte(8'(i));
    idle_cycles(0);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_flag", bus.overflow, 1);
    repeat (5) @(negedge clk);
    busy_force = 1'b0;
    wait_starts("ovf_drain", n0 + 16, 300);
    repeat (20) @(negedge clk);
    check("ovf_sent_count", sent_data.size() - n0, 16);
    for (int i = 0; i < 16; i++) check("ovf_data", sent_data[n0 + i], 8'(i));
    check("ovf_sticky", bus.overflow, 1);

    // Push and pop in the same cycle while full.
    pulse_reset();
    busy_force = 1'b1;
    n0 = sent_data.size();
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    @(negedge clk);
    check("pp_full_before", bus.full, 1);
    busy_force  = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("pp_count_kept", bus.count, 16);
    wait_starts("pp_drain", n0 + 17, 300);
    check("pp_first", sent_data[n0], 8'h20);
    check("pp_last", sent_data[n0 + 16], 8'hEE);
    check("pp_overflow", bus.overflow, 0);

    // Timeout path: transmitter never raises busy.
    pulse_reset();
    n0 = sent_data.size();
    write_byte(8'h3C);
    w = cyc;
    write_byte(8'hC3);
    idle_cycles(0);
    wait_starts("to_wait", n0 + 2, 50);
    check("to_latency", sent_cyc[n0] - w, 2);
    check("to_gap", sent_cyc[n0 + 1] - sent_cyc[n0], 5);
    check("to_data0", sent_data[n0], 8'h3C);
    check("to_data1", sent_data[n0 + 1], 8'hC3);

    // Reset with bytes queued and one in flight.
    busy_auto = 1'b1;
    n0 = sent_data.size();
    for (int i = 0; i < 6; i++) write_byte(8'h50 + 8'(i));
    idle_cycles(0);
    wait_starts("mid_first", n0 + 1, 20);
    repeat (3) @(negedge clk);
    check("mid_count_before", bus.count, 5);
    pulse_reset();
    check("mid_count", bus.count, 0);
    check("mid_empty", bus.empty, 1);
    check("mid_start", bus.txd_start, 0);
    check("mid_overflow", bus.overflow, 0);
    n1 = sent_data.size();
    repeat (40) @(negedge clk);
    check("mid_no_more_starts", sent_data.size(), n1);
    busy_auto = 1'b0;
    n0 = sent_data.size();
    write_byte(8'h77);
    w = cyc;
    idle_cycles(0);
    wait_starts("mid_restart", n0 + 1, 20);
    check("mid_restart_latency", sent_cyc[n0] - w, 2);
    check("mid_restart_data", sent_data[n0], 8'h77);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus transmit sequencer between a byte producer (e.g. `async_receiver` `RxD_data_ready`/`RxD_data`, or a later hash-result formatter) and `async_transmitter`.
- Absorbs bursts that arrive faster than the UART can send. Drains one byte at a time, honouring `TxD_busy`.
- Lets the loopback and later Ducky command paths run at maximum baud without losing back-to-back bytes.

Parameters:
- `DEPTH`, 16, FIFO entries; must be a power of 2, minimum 2.
- `ADDR_W`, 4, log2(`DEPTH`); pointer width.
- `BUSY_TIMEOUT`, 3, cycles to wait in `WAIT_BUSY` for `txd_busy` to rise before treating the byte as sent.

Ports:
- `clk`  input  1  system clock (12 MHz on iCE40HX-8K).
- `reset_n`  input  1  synchronous, active-low reset.
- `wr_en`  input  1  write strobe; one byte per cycle while high.
- `wr_data`  input  8  byte to enqueue.
- `full`  output  1  FIFO holds `DEPTH` entries.
- `empty`  output  1  FIFO holds 0 entries.
- `count`  output  `ADDR_W`+1  current occupancy, 0..`DEPTH`.
- `overflow`  output  1  sticky; a write was dropped.
- `txd_start`  output  1  one-cycle start pulse to the transmitter.
- `txd_data`  output  8  byte for the transmitter; stable from `txd_start` until the next load.
- `txd_busy`  input  1  transmitter busy, from `async_transmitter` `TxD_busy`.

Behaviour:
- Reset: `reset_n` is sampled on the `clk` rising edge only.
  - Reset values: `rd_ptr`=`wr_ptr`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `txd_start`=0, `txd_data`=8'h00, FSM=`IDLE`.
  - Reset mid-transmission discards all queued bytes and returns to `IDLE` immediately. A byte already handed to the transmitter finishes on the line; that is not this block's concern.
- Storage: `DEPTH` x 8 register/BRAM array; `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap naturally from `DEPTH`-1 to 0.
- `full`, `empty`, `count`: registered, derived from the `count` register, valid the cycle after any change.
- Push: `wr_en`=1 and (`full`=0 or pop in the same cycle) -> store at `wr_ptr`, increment `wr_ptr`.
- Simultaneous push and pop:
  - `count` unchanged.
  - When full, the write is accepted.
  - When empty, the pop cannot occur (the pop requires `empty`=0), so only the push happens.
- Overflow: `wr_en`=1, `full`=1 and no pop -> byte dropped, pointers unchanged, `overflow`<=1. `overflow` is cleared only by reset.
- FSM states: `IDLE`, `WAIT_BUSY`, `WAIT_DONE`.
  - `IDLE`: if `empty`=0 and `txd_busy`=0 -> pop (`txd_data`<=mem[`rd_ptr`], increment `rd_ptr`, `txd_start`<=1 for exactly one cycle), load timeout counter with `BUSY_TIMEOUT`, go to `WAIT_BUSY`. Otherwise stay.
  - `WAIT_BUSY`:
    - `txd_busy`=1 -> `WAIT_DONE`.
    - Else decrement the counter; on reaching 0 -> `IDLE`. The byte counts as consumed; this prevents a hang if the transmitter missed the start.
  - `WAIT_DONE`: `txd_busy`=0 -> `IDLE`.
- Latency: with the FIFO empty, `IDLE` and `txd_busy`=0, `wr_en` in cycle 0 -> `empty`=0 in cycle 1 -> `txd_start`=1 in cycle 2.
- Back-to-back transmit: the minimum gap between consecutive `txd_start` pulses is 1 cycle plus the transmitter busy time; `txd_start` is never asserted while `txd_busy`=1.
- `txd_start` is never high in two consecutive cycles.

Decomposition:
- Shared package/header holds the FSM state encodings (2-bit `IDLE`=0, `WAIT_BUSY`=1, `WAIT_DONE`=2) and the `BUSY_TIMEOUT` default.
- One natural sub-module: `sync_fifo` (generic `DEPTH`/`WIDTH` storage, pointers, flags, overflow); `uart_tx_fifo` wraps it with the transmit FSM.
- Target total is about 150-250 lines of RTL.

Test Plan:
- Single byte: reset, then `wr_en`=1 with 8'hA5 for 1 cycle, `txd_busy`=0 -> `txd_start` pulses in cycle 2 with `txd_data`=8'hA5, `count` returns to 0, `empty`=1.
- Burst with busy model: write 8'h01..8'h10 on 16 consecutive cycles; the transmitter model holds `txd_busy`=1 for 20 cycles per start, starting 1 cycle after `txd_start` -> 16 `txd_start` pulses, data 8'h01..8'h10 in order, none while busy, `overflow`=0.
- Overflow: `txd_busy` held at 1; write 17 bytes 8'h00..8'h10 -> `full`=1 after 16, 17th dropped, `overflow`=1 sticky. Release busy -> exactly 8'h00..8'h0F transmitted.
- Push+pop when full: FIFO full, and in the pop cycle `wr_en`=1 with 8'hEE -> `count` stays 16, and 8'hEE is transmitted last.
- Timeout: `txd_busy` tied to 0, write 8'h3C, 8'hC3 -> each byte transmitted. `WAIT_BUSY` exits after 3 cycles, so `txd_start` pulses are 5 cycles apart (pop, 3 timeout cycles, `IDLE`); no hang.
- Reset mid-operation: 5 bytes queued, one in flight; `reset_n`=0 for 1 cycle -> next cycle `count`=0, `empty`=1, `txd_start`=0, FSM=`IDLE`, `overflow`=0, and no further `txd_start` without new writes.
